// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish evaluation controller driving a push/pop stack port.
// Optional multiplier for opcode 2 is enabled by defining RPN_MUL_EN.
module rpn_stack_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [WIDTH-1:0] stk_data_in,
  output logic             stk_read_write,
  output logic             stk_enable,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_e_flag,
  input  logic             stk_f_flag
);

`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_EMIT = 2'd3;

  localparam logic [1:0] E_UNDER   = 2'b01;
  localparam logic [1:0] E_OVER    = 2'b10;
  localparam logic [1:0] E_ILLEGAL = 2'b11;

  typedef enum logic [3:0] {
    IDLE, PUSH, POP_B, CAP_B, POP_A, CAP_A, WB, EMIT_POP, EMIT_CAP, ERR
  } state_t;

  state_t           state, state_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [WIDTH-1:0] opnd_q, a_q, b_q, res_q;
  logic [1:0]       op_q;
  logic             accept;

  // Wrapping arithmetic; the multiplier only exists when RPN_MUL_EN is defined.
  function automatic logic [WIDTH-1:0] alu_wrap(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SUB:  r = a - b;
`ifdef RPN_MUL_EN
      OP_MUL:  r = a * b;
`endif
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign accept = tok_valid && (state == IDLE);

  always_comb begin
    state_d    = state;
    err_code_d = err_code_q;
    case (state)
      IDLE: begin
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (stk_f_flag) begin
              state_d    = ERR;
              err_code_d = E_OVER;
            end else begin
              state_d = PUSH;
            end
          end else if (tok_data[1:0] == OP_MUL && !MUL_EN) begin
            state_d    = ERR;
            err_code_d = E_ILLEGAL;
          end else if (stk_e_flag) begin
            state_d    = ERR;
            err_code_d = E_UNDER;
          end else if (tok_data[1:0] == OP_EMIT) begin
            state_d = EMIT_POP;
          end else begin
            state_d = POP_B;
          end
        end
      end
      PUSH:     state_d = IDLE;
      POP_B:    state_d = CAP_B;
      CAP_B: begin
        // The second operand is missing once the first pop leaves the stack empty.
        if (stk_e_flag) begin
          state_d    = ERR;
          err_code_d = E_UNDER;
        end else begin
          state_d = POP_A;
        end
      end
      POP_A:    state_d = CAP_A;
      CAP_A:    state_d = WB;
      WB:       state_d = IDLE;
      EMIT_POP: state_d = EMIT_CAP;
      EMIT_CAP: state_d = IDLE;
      ERR:      state_d = ERR;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      err_code_q <= 2'b00;
    end else begin
      state      <= state_d;
      err_code_q <= err_code_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd_q <= '0;
      op_q   <= 2'b00;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        opnd_q <= tok_data;
        op_q   <= tok_data[1:0];
      end
      if (state == CAP_B)    b_q   <= stk_data_out;
      if (state == CAP_A)    a_q   <= stk_data_out;
      if (state == EMIT_CAP) res_q <= stk_data_out;
    end
  end

  always_comb begin
    stk_enable     = 1'b0;
    stk_read_write = 1'b0;
    stk_data_in    = '0;
    case (state)
      PUSH: begin
        stk_enable  = 1'b1;
        stk_data_in = opnd_q;
      end
      POP_B, POP_A, EMIT_POP: begin
        stk_enable     = 1'b1;
        stk_read_write = 1'b1;
      end
      WB: begin
        stk_enable  = 1'b1;
        stk_data_in = alu_wrap(op_q, a_q, b_q);
      end
      default: ;
    endcase
  end

  assign tok_ready = (state == IDLE);
  assign err       = (state == ERR);
  assign err_code  = err_code_q;
  assign res_valid = (state == EMIT_CAP);
  // Popped value is live on the stack output during the pulse; hold it afterwards.
  assign res_data  = (state == EMIT_CAP) ? stk_data_out : res_q;

endmodule
